demux1to8_deser: RTL and testbench

DEMUX1TO8_DESER -- requirements
Module: demux1to8_deser

---
 rtl/demux1to8_deser.sv | 125 ++++++++++++
 tb/tb_demux1to8_deser.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1to8_deser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// demux1to8_deser : 1-to-8 bit distributor / deserializer, addressed or auto-sequenced
// Revision: 1.0
// ---------------------------------------------------------------------------
module demux1to8_deser #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       mode,
  input  logic [2:0] sel,
  output logic [7:0] data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] fill,
  output logic       dup_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [2:0] START_IDX = LSB_FIRST ? 3'd0 : 3'd7;

  state_t     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [7:0] mask_q, mask_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] fill_q, fill_d;
  logic       mode_q, mode_d;
  logic       dup_err_q, dup_err_d;

  logic       accept;
  logic       deliver;
  logic       auto_mode;
  logic [2:0] pos;

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;
  // The live mode input only matters for the very first bit of a word.
  assign auto_mode = (state_q == IDLE) ? mode : mode_q;
  assign pos       = auto_mode ? idx_q : sel;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    mask_d    = mask_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    dup_err_d = 1'b0;

    if (accept) begin
      data_d[pos] = in_bit;
      mask_d[pos] = 1'b1;
      dup_err_d   = !auto_mode && mask_q[pos];
      if (auto_mode) begin
        idx_d = LSB_FIRST ? (idx_q + 3'd1) : (idx_q - 3'd1);
      end
    end

    if (deliver) begin
      mask_d = 8'h00;
      idx_d  = START_IDX;
    end

    fill_d = 4'd0;
    for (int i = 0; i < 8; i++) begin
      fill_d = fill_d + {3'b000, mask_d[i]};
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = COLLECT;
          mode_d  = mode;
        end
      end
      COLLECT: begin
        if (accept && (mask_d == 8'hFF)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (deliver) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      data_q    <= 8'h00;
      mask_q    <= 8'h00;
      idx_q     <= START_IDX;
      fill_q    <= 4'd0;
      mode_q    <= 1'b0;
      dup_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      idx_q     <= idx_d;
      fill_q    <= fill_d;
      mode_q    <= mode_d;
      dup_err_q <= dup_err_d;
    end
  end

  assign data    = data_q;
  assign fill    = fill_q;
  assign dup_err = dup_err_q;

endmodule
`default_nettype wire

// File: tb/tb_demux1to8_deser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_demux1to8_deser : randomized self-checking bench against a word-level model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_demux1to8_deser;

  localparam bit LSB = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       mode = 1'b0;
  logic [2:0] sel = 3'd0;
  logic [7:0] data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] fill;
  logic       dup_err;

  int checks = 0;
  int failures = 0;

  // Model of the word being assembled.
  logic [7:0] m_data;
  logic [7:0] m_mask;
  logic       m_auto;
  int         m_cnt;
  logic       m_hold;
  logic       exp_dup;
  logic       exp_rdy;
  logic       obs_rdy;
  int         words;

  demux1to8_deser #(.LSB_FIRST(LSB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .data      (data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fill      (fill),
    .dup_err   (dup_err)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_data  = 8'h00;
    m_mask  = 8'h00;
    m_auto  = 1'b0;
    m_cnt   = 0;
    m_hold  = 1'b0;
    exp_dup = 1'b0;
  endtask

  // Apply one cycle of stimulus, advance the model, and step past the edge.
  task automatic drive_cycle(input logic v, input logic b, input logic md,
                             input logic [2:0] s, input logic ordy);
    int pos;
    in_valid  = v;
    in_bit    = b;
    mode      = md;
    sel       = s;
    out_ready = ordy;
    exp_rdy   = !m_hold;
    exp_dup   = 1'b0;
    #1;
    obs_rdy = in_ready;
    if (m_hold) begin
      if (ordy) begin
        m_hold = 1'b0;
        m_mask = 8'h00;
        m_cnt  = 0;
        words++;
      end
    end else if (v) begin
      if (m_mask == 8'h00) m_auto = md;
      pos = m_auto ? (LSB ? m_cnt : 7 - m_cnt) : int'(s);
      exp_dup = !m_auto && m_mask[pos];
      m_data[pos] = b;
      m_mask[pos] = 1'b1;
      m_cnt++;
      if (m_mask == 8'hFF) m_hold = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    model_clear();
    #3;
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++; if (fill !== 4'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (dup_err !== 1'b0) begin failures++; $display("FAIL reset_dup_err got=%b exp=0", dup_err); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_auto_aa();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 1'(i % 2), 1'b1, 3'(7 - i), 1'b0);
      if (i == 6) begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL auto_early_valid got=%b exp=0", out_valid); end
      end
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL auto_out_valid got=%b exp=1", out_valid); end
    checks++; if (data !== 8'hAA) begin failures++; $display("FAIL auto_data got=%h exp=aa", data); end
    checks++; if (fill !== 4'd8) begin failures++; $display("FAIL auto_fill got=%0d exp=8", fill); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL auto_in_ready got=%b exp=0", in_ready); end
    drive_cycle(1'b1, 1'b1, 1'b1, 3'd0, 1'b1);
    checks++; if (obs_rdy !== 1'b0) begin failures++; $display("FAIL auto_deliver_ready got=%b exp=0", obs_rdy); end
    checks++; if (out_valid !== 1'b0 || fill !== 4'd0 || data !== 8'hAA) begin
      failures++; $display("FAIL auto_deliver got=ov%b fill%0d data%h exp=ov0 fill0 dataaa", out_valid, fill, data);
    end
  endtask

  task automatic test_addressed();
    for (int i = 7; i >= 0; i--) begin
      drive_cycle(1'b1, 1'(i % 2), 1'b0, 3'(i), 1'b0);
    end
    checks++; if (data !== 8'hAA || out_valid !== 1'b1) begin
      failures++; $display("FAIL addr_word got=data%h ov%b exp=dataaa ov1", data, out_valid);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    checks++; if (fill !== 4'd0 || data !== 8'hAA || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL addr_deliver got=fill%0d data%h rdy%b ov%b exp=fill0 dataaa rdy1 ov0",
                           fill, data, in_ready, out_valid);
    end
  endtask

  task automatic test_dup();
    logic [2:0] seq [9];
    logic       bits [9];
    seq  = '{3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    bits = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      drive_cycle(1'b1, bits[i], 1'b0, seq[i], 1'b0);
      checks++; if (dup_err !== exp_dup) begin
        failures++; $display("FAIL dup_pulse step=%0d got=%b exp=%b", i, dup_err, exp_dup);
      end
      checks++; if (fill !== 4'($countones(m_mask))) begin
        failures++; $display("FAIL dup_fill step=%0d got=%0d exp=%0d", i, fill, $countones(m_mask));
      end
      checks++; if (out_valid !== (i == 8)) begin
        failures++; $display("FAIL dup_out_valid step=%0d got=%b exp=%b", i, out_valid, (i == 8));
      end
    end
    checks++; if (data[3] !== 1'b0 || data !== m_data) begin
      failures++; $display("FAIL dup_data got=%h exp=%h", data, m_data);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
  endtask

  task automatic test_hold_stall();
    logic [7:0] w;
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'($urandom), 1'b1, 3'd0, 1'b0);
    w = m_data;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 1'($urandom), 1'($urandom), 3'($urandom), 1'b0);
      checks++; if (data !== w || fill !== 4'd8 || out_valid !== 1'b1 || obs_rdy !== 1'b0) begin
        failures++; $display("FAIL hold_stall cyc=%0d got=data%h fill%0d ov%b rdy%b exp=data%h fill8 ov1 rdy0",
                             i, data, fill, out_valid, obs_rdy, w);
      end
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++; if (data !== 8'h00 || fill !== 4'd0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid got=data%h fill%0d ov%b exp=data00 fill0 ov0", data, fill, out_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 1'($urandom), 1'b1, 3'd0, 1'b0);
      checks++; if (data !== m_data || fill !== 4'(i + 1) || out_valid !== (i == 7)) begin
        failures++; $display("FAIL rst_refill step=%0d got=data%h fill%0d ov%b exp=data%h fill%0d ov%b",
                             i, data, fill, out_valid, m_data, i + 1, (i == 7));
      end
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
  endtask

  task automatic test_random();
    int cyc;
    int start_words;
    start_words = words;
    cyc = 0;
    while ((words - start_words) < 20 && cyc < 5000) begin
      drive_cycle(($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom), 3'($urandom),
                  ($urandom_range(0, 1) == 1));
      cyc++;
      checks++; if (data !== m_data || fill !== 4'($countones(m_mask)) || out_valid !== m_hold ||
                    dup_err !== exp_dup || obs_rdy !== exp_rdy) begin
        failures++; $display("FAIL random cyc=%0d got=data%h fill%0d ov%b dup%b rdy%b exp=data%h fill%0d ov%b dup%b rdy%b",
                             cyc, data, fill, out_valid, dup_err, obs_rdy,
                             m_data, $countones(m_mask), m_hold, exp_dup, exp_rdy);
      end
    end
    checks++; if ((words - start_words) < 20) begin
      failures++; $display("FAIL random_words got=%0d exp=20", words - start_words);
    end
  endtask

  initial begin
    words = 0;
    model_clear();
    test_reset();
    test_auto_aa();
    test_addressed();
    test_dup();
    test_hold_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
